// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths and skid-buffer entry type for the writeback arbiter
package wb_arbiter_pkg;

  localparam int XLEN           = 32;
  localparam int RF_IDX_WIDTH   = 5;
  localparam int CSR_ADDR_WIDTH = 12;

  typedef struct packed {
    logic                    valid;
    logic [RF_IDX_WIDTH-1:0] rd;
    logic [XLEN-1:0]         data;
  } wb_entry_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// rtl/wb_skid_fifo.sv - in-order skid buffer with push/pop, kill-by-rd and age-ordered read-out
module wb_skid_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  wb_entry_t                     push_entry_i,
  input  logic                          pop_i,
  input  logic                          kill_i,
  input  logic [RF_IDX_WIDTH-1:0]       kill_rd_i,
  output wb_entry_t                     head_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output wb_entry_t [DEPTH-1:0]         entries_o
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]         head_q;
  logic [PW-1:0]         tail_q;
  logic [PW:0]           count_q;

  // Popped slots are invalidated so empty slots never look like live entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_i && (mem_q[i].rd == kill_rd_i)) begin
          mem_q[i].valid <= 1'b0;
        end
      end
      if (pop_i) begin
        mem_q[head_q].valid <= 1'b0;
        head_q              <= head_q + 1'b1;
      end
      if (push_i) begin
        mem_q[tail_q] <= push_entry_i;
        tail_q        <= tail_q + 1'b1;
      end
      count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

  // entries_o[0] is the oldest entry, higher indices are younger.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_o[i] = mem_q[head_q + PW'(i)];
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging EX, load and CSR results; WB_FWD_EN enables forwarding
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_en,
  input  logic [RF_IDX_WIDTH-1:0]   ex_rd,
  input  logic [XLEN-1:0]           ex_data,
  input  logic                      m_en,
  input  logic [RF_IDX_WIDTH-1:0]   m_rd,
  input  logic [XLEN-1:0]           m_data,
  input  logic                      csr_en,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_idx,
  input  logic [XLEN-1:0]           csr_data,
  output logic                      rf_we,
  output logic [RF_IDX_WIDTH-1:0]   rf_waddr,
  output logic [XLEN-1:0]           rf_wdata,
  output logic                      csr_we,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr,
  output logic [XLEN-1:0]           csr_wdata,
  output logic                      wb_stall,
  output logic                      wb_ovf,
  input  logic [RF_IDX_WIDTH-1:0]   rs1_idx,
  input  logic [RF_IDX_WIDTH-1:0]   rs2_idx,
  output logic                      fwd1_hit,
  output logic                      fwd2_hit,
  output logic [XLEN-1:0]           fwd1_data,
  output logic [XLEN-1:0]           fwd2_data
);

  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 1);

  logic                      m_act, ex_act;
  logic                      push, pop, push_ok, ovf_set;
  logic [CW-1:0]             count, count_nxt;
  wb_entry_t                 head, ex_entry;
  wb_entry_t [DEPTH-1:0]     entries;

  logic                      rf_we_d, rf_we_q;
  logic [RF_IDX_WIDTH-1:0]   rf_waddr_d, rf_waddr_q;
  logic [XLEN-1:0]           rf_wdata_d, rf_wdata_q;
  logic                      csr_we_q;
  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_q;
  logic [XLEN-1:0]           csr_wdata_q;
  logic                      stall_q, ovf_q;

  // x0 writes vanish here, before they can reach the port or the buffer.
  assign m_act    = m_en && (m_rd != '0);
  assign ex_act   = ex_en && (ex_rd != '0);
  assign ex_entry = '{valid: 1'b1, rd: ex_rd, data: ex_data};

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    push       = 1'b0;
    pop        = 1'b0;
    if (m_act) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = m_rd;
      rf_wdata_d = m_data;
      push       = ex_act;
    end else if (count != '0) begin
      pop        = 1'b1;
      rf_we_d    = head.valid;
      rf_waddr_d = head.rd;
      rf_wdata_d = head.data;
      push       = ex_act;
    end else if (ex_act) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = ex_rd;
      rf_wdata_d = ex_data;
    end
    push_ok   = push && ((count != FULL) || pop);
    ovf_set   = push && !push_ok;
    count_nxt = count + CW'(push_ok) - CW'(pop);
  end

  wb_skid_fifo #(.DEPTH(DEPTH)) u_skid (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_ok),
    .push_entry_i (ex_entry),
    .pop_i        (pop),
    .kill_i       (m_act),
    .kill_rd_i    (m_rd),
    .head_o       (head),
    .count_o      (count),
    .entries_o    (entries)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      csr_we_q    <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
      stall_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      csr_we_q    <= csr_en;
      csr_waddr_q <= csr_idx;
      csr_wdata_q <= csr_data;
      stall_q     <= (count_nxt >= STALL_LVL);
      ovf_q       <= ovf_q | ovf_set;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign csr_we    = csr_we_q;
  assign csr_waddr = csr_waddr_q;
  assign csr_wdata = csr_wdata_q;
  assign wb_stall  = stall_q;
  assign wb_ovf    = ovf_q;

`ifdef WB_FWD_EN
  logic [1:0]              fwd_hit;
  logic [XLEN-1:0]         fwd_data [2];
  logic [RF_IDX_WIDTH-1:0] rs_idx   [2];

  assign rs_idx[0] = rs1_idx;
  assign rs_idx[1] = rs2_idx;

  // Later matches override earlier ones, so the youngest source wins.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      fwd_hit[k]  = 1'b0;
      fwd_data[k] = '0;
      if (rs_idx[k] != '0) begin
        if (rf_we_q && (rf_waddr_q == rs_idx[k])) begin
          fwd_hit[k]  = 1'b1;
          fwd_data[k] = rf_wdata_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (entries[i].valid && (entries[i].rd == rs_idx[k])) begin
            fwd_hit[k]  = 1'b1;
            fwd_data[k] = entries[i].data;
          end
        end
      end
    end
  end

  assign fwd1_hit  = fwd_hit[0];
  assign fwd2_hit  = fwd_hit[1];
  assign fwd1_data = fwd_data[0];
  assign fwd2_data = fwd_data[1];
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs1_idx, rs2_idx, entries};
  assign fwd1_hit   = 1'b0;
  assign fwd2_hit   = 1'b0;
  assign fwd1_data  = '0;
  assign fwd2_data  = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter against a queue-based writeback model
module tb_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_en = 0, m_en = 0, csr_en = 0;
  logic [4:0]  ex_rd = 0, m_rd = 0, rs1_idx = 0, rs2_idx = 0;
  logic [31:0] ex_data = 0, m_data = 0, csr_data = 0;
  logic [11:0] csr_idx = 0;
  logic        rf_we, csr_we, wb_stall, wb_ovf, fwd1_hit, fwd2_hit;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, csr_wdata, fwd1_data, fwd2_data;
  logic [11:0] csr_waddr;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ex_en(ex_en), .ex_rd(ex_rd), .ex_data(ex_data),
    .m_en(m_en), .m_rd(m_rd), .m_data(m_data),
    .csr_en(csr_en), .csr_idx(csr_idx), .csr_data(csr_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .wb_stall(wb_stall), .wb_ovf(wb_ovf),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
  );

  typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; } wr_t;
  typedef struct { int cyc; logic [11:0] idx; logic [31:0] data; } cw_t;
  typedef struct { bit v; logic [4:0] rd; logic [31:0] data; } ent_t;

  wr_t         rf_exp[$];
  cw_t         csr_exp[$];
  ent_t        mq[$];
  bit          st_v[8192];
  bit          st_stall[8192];
  bit          st_ovf[8192];
  bit          m_ovf = 0;
  bit          last_we = 0;
  logic [4:0]  last_rd = 0;
  logic [31:0] last_data = 0;
  logic [31:0] shadow[32];
  int          cyc = 0, n_chk = 0, n_fail = 0;
  bit          mon_en = 0;
  wr_t         we_pop;
  cw_t         ce_pop;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (rf_exp.size() > 0 && rf_exp[0].cyc < cyc) begin
        check("rf_write_missing_at_cycle", cyc, rf_exp[0].cyc);
        void'(rf_exp.pop_front());
      end
      if (rf_we) begin
        if (rf_exp.size() == 0) check("rf_unexpected_write_pending", rf_exp.size(), 1);
        else begin
          we_pop = rf_exp.pop_front();
          check("rf_write_cycle", cyc, we_pop.cyc);
          check("rf_waddr", rf_waddr, we_pop.rd);
          check("rf_wdata", rf_wdata, we_pop.data);
        end
        shadow[rf_waddr] = rf_wdata;
      end
      while (csr_exp.size() > 0 && csr_exp[0].cyc < cyc) begin
        check("csr_write_missing_at_cycle", cyc, csr_exp[0].cyc);
        void'(csr_exp.pop_front());
      end
      if (csr_we) begin
        if (csr_exp.size() == 0) check("csr_unexpected_write_pending", csr_exp.size(), 1);
        else begin
          ce_pop = csr_exp.pop_front();
          check("csr_write_cycle", cyc, ce_pop.cyc);
          check("csr_waddr", csr_waddr, ce_pop.idx);
          check("csr_wdata", csr_wdata, ce_pop.data);
        end
      end
      if (st_v[cyc]) begin
        check("wb_stall", wb_stall, st_stall[cyc]);
        check("wb_ovf", wb_ovf, st_ovf[cyc]);
      end
    end
  end

  task automatic model_fwd(input logic [4:0] r, output logic hit, output logic [31:0] d);
    hit = 0;
    d   = 0;
    if (r != 0) begin
      if (last_we && last_rd == r) begin hit = 1; d = last_data; end
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].v && mq[i].rd == r) begin hit = 1; d = mq[i].data; end
    end
  endtask

  task automatic fwd_check();
    logic [4:0]  r1, r2;
    logic        h;
    logic [31:0] d;
    r1 = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[mq.size()-1].rd : 5'($urandom_range(0, 15));
    r2 = last_we ? last_rd : 5'($urandom_range(0, 15));
    rs1_idx = r1;
    rs2_idx = r2;
    #1;
`ifdef WB_FWD_EN
    model_fwd(r1, h, d);
    check("fwd1_hit", fwd1_hit, h);
    check("fwd1_data", fwd1_data, d);
    model_fwd(r2, h, d);
    check("fwd2_hit", fwd2_hit, h);
    check("fwd2_data", fwd2_data, d);
`else
    h = 0;
    d = 0;
    check("fwd1_hit_off", fwd1_hit, h);
    check("fwd1_data_off", fwd1_data, d);
    check("fwd2_hit_off", fwd2_hit, h);
    check("fwd2_data_off", fwd2_data, d);
`endif
  endtask

  // Drive one cycle, derive the expected outcome from the writeback rules, then wait for the next negedge.
  task automatic step(input bit ee, input logic [4:0] er, input logic [31:0] ed,
                      input bit me, input logic [4:0] mr, input logic [31:0] md,
                      input bit ce, input logic [11:0] ci, input logic [31:0] cd);
    bit          ea, ma, wr;
    logic [4:0]  wrd;
    logic [31:0] wd;
    ent_t        h;
    ex_en = ee; ex_rd = er; ex_data = ed;
    m_en = me; m_rd = mr; m_data = md;
    csr_en = ce; csr_idx = ci; csr_data = cd;
    ea = ee && er != 0;
    ma = me && mr != 0;
    wr = 0; wrd = 0; wd = 0;
    if (ma) begin
      wr = 1; wrd = mr; wd = md;
      foreach (mq[i]) if (mq[i].rd == mr) mq[i].v = 0;
      if (ea) begin
        if (mq.size() >= DEPTH) m_ovf = 1;
        else mq.push_back('{1'b1, er, ed});
      end
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      wr = h.v; wrd = h.rd; wd = h.data;
      if (ea) mq.push_back('{1'b1, er, ed});
    end else if (ea) begin
      wr = 1; wrd = er; wd = ed;
    end
    if (wr) rf_exp.push_back('{cyc + 1, wrd, wd});
    last_we = wr; last_rd = wrd; last_data = wd;
    if (ce) csr_exp.push_back('{cyc + 1, ci, cd});
    st_v[cyc+1]     = 1;
    st_stall[cyc+1] = (mq.size() >= DEPTH - 1);
    st_ovf[cyc+1]   = m_ovf;
    @(negedge clk);
    fwd_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_steps(input int n, input bit obey_stall);
    bit ee, me, ce;
    for (int i = 0; i < n; i++) begin
      me = ($urandom_range(0, 2) == 0);
      ee = ($urandom_range(0, 1) == 1) && (!obey_stall || mq.size() < DEPTH - 1);
      ce = ($urandom_range(0, 3) == 0);
      step(ee, 5'($urandom_range(0, 7)), $urandom, me, 5'($urandom_range(0, 7)), $urandom,
           ce, 12'($urandom), $urandom);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rf_we"}, rf_we, 0);
    check({tag, "_rf_waddr"}, rf_waddr, 0);
    check({tag, "_rf_wdata"}, rf_wdata, 0);
    check({tag, "_csr_we"}, csr_we, 0);
    check({tag, "_csr_waddr"}, csr_waddr, 0);
    check({tag, "_csr_wdata"}, csr_wdata, 0);
    check({tag, "_wb_stall"}, wb_stall, 0);
    check({tag, "_wb_ovf"}, wb_ovf, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (shadow[i]) shadow[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 0;
    mon_en = 1;

    step(1, 5, 32'h11, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 6, 32'h22, 0, 0, 0);
    idle(2);

    step(1, 4, 32'hBB, 1, 3, 32'hAA, 0, 0, 0);
    idle(2);

    step(1, 7, 32'h1, 1, 1, 32'h9, 0, 0, 0);
    step(0, 0, 0, 1, 7, 32'h2, 0, 0, 0);
    idle(3);
    check("kill_final_r7", shadow[7], 32'h2);

    step(1, 0, 32'h77, 0, 0, 0, 1, 12'h300, 32'h8);
    idle(2);

    step(1, 9, 32'h5, 1, 9, 32'h4, 0, 0, 0);
`ifdef WB_FWD_EN
    rs1_idx = 9;
    #1;
    check("fwd_directed_hit", fwd1_hit, 1);
    check("fwd_directed_data", fwd1_data, 32'h5);
`endif
    idle(2);
    check("final_r9", shadow[9], 32'h5);

    rand_steps(250, 1);
    idle(3);

    for (int i = 0; i < 3; i++) step(1, 5'(10 + i), 32'hC0 + i, 1, 5'(20 + i), 32'hD0 + i, 0, 0, 0);
    idle(4);
    check("ovf_sticky", wb_ovf, 1);

    rand_steps(100, 0);

    step(1, 12, 32'h123, 1, 13, 32'h456, 0, 0, 0);
    #3;
    rst = 1;
    mon_en = 0;
    #1;
    check_outputs_zero("midreset");
    mq.delete();
    rf_exp.delete();
    csr_exp.delete();
    m_ovf = 0;
    last_we = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    mon_en = 1;

    rand_steps(60, 1);
    idle(4);
    check("rf_exp_drained", rf_exp.size(), 0);
    check("csr_exp_drained", csr_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
